// File: rtl/instr_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_stream_loader
// Description : Receive-side boot loader. Frames the byte-per-cycle
//               instruction stream (start / end / escape bytes), packs four
//               payload bytes per 32-bit word (first byte in [31:24]) and
//               writes the words to consecutive instruction-memory addresses.
//               Signals the core to run once the image is complete.
//               Optional macro LOADER_CHECKSUM_EN adds a trailing XOR
//               checksum byte after the end byte.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_stream_loader #(
  parameter int         ADDR_W     = 6,
  parameter logic [7:0] START_BYTE = 8'hFE,
  parameter logic [7:0] END_BYTE   = 8'hFF,
  parameter logic [7:0] ESC_BYTE   = 8'hFD
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [7:0]        instr_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              run_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              err_o
);

  // Word count at which the memory is full; further words are dropped.
  localparam logic [ADDR_W:0] C_WORD_CAP = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ESC   = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    ST_CKSUM = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [23:0]         buf_q, buf_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                run_q, run_d;
  logic                err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  logic                w_take;   // sampled byte is payload
  logic                w_start;  // sampled byte (re)starts an image

  // Next-state and datapath: framing decode, word packing, overflow and error tracking.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    run_d   = 1'b0;
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    w_take  = 1'b0;
    w_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_i == START_BYTE) w_start = 1'b1;
      end
      ST_LOAD: begin
        if (instr_i == ESC_BYTE) begin
          state_d = ST_ESC;
        end else if (instr_i == END_BYTE) begin
          // A partial trailing word is dropped and flagged.
          if (idx_q != 2'd0) err_d = 1'b1;
          idx_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          state_d = ST_CKSUM;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
          run_d   = ~(err_q | (idx_q != 2'd0));
`endif
        end else begin
          w_take = 1'b1;
        end
      end
      ST_ESC: begin
        w_take  = 1'b1;
        state_d = ST_LOAD;
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CKSUM: begin
        // Checksum byte is taken raw, never unescaped.
        if (instr_i != xor_q) err_d = 1'b1;
        state_d = ST_DONE;
        done_d  = 1'b1;
        run_d   = ~(err_q | (instr_i != xor_q));
      end
`endif
      ST_DONE: begin
        if (instr_i == START_BYTE) w_start = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_start) begin
      state_d = ST_LOAD;
      idx_d   = 2'd0;
      buf_d   = 24'd0;
      addr_d  = '0;
      cnt_d   = '0;
      waddr_d = '0;
      err_d   = 1'b0;
      done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_d   = 8'd0;
`endif
    end

    if (w_take) begin
      buf_d = {buf_q[15:0], instr_i};
      idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
      xor_d = xor_q ^ instr_i;
`endif
      if (idx_q == 2'd3) begin
        if (cnt_q == C_WORD_CAP) begin
          // Memory full: drop the word, count saturates.
          err_d = 1'b1;
        end else begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {buf_q, instr_i};
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + (ADDR_W+1)'(1);
        end
      end
    end

`ifdef LOADER_CHECKSUM_EN
    busy_d = (state_d == ST_LOAD) || (state_d == ST_ESC) || (state_d == ST_CKSUM);
`else
    busy_d = (state_d == ST_LOAD) || (state_d == ST_ESC);
`endif
  end

  // State and registered outputs; asynchronous reset returns everything to zero / IDLE.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      buf_q   <= 24'd0;
      addr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      run_q   <= run_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = waddr_q;
  assign imem_wdata_o = wdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign run_o        = run_q;
  assign word_cnt_o   = cnt_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_stream_loader
// Description : Directed self-checking bench for instr_stream_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_instr_stream_loader;

  localparam int ADDR_W = 6;

  logic              clk_i;
  logic              reset;
  logic [7:0]        instr_i;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_wdata_o;
  logic              busy_o;
  logic              done_o;
  logic              run_o;
  logic [ADDR_W:0]   word_cnt_o;
  logic              err_o;

  int n_checks = 0;
  int n_errors = 0;

  // Write / pulse log gathered by the monitor.
  int          wr_n     = 0;
  int          run_cnt  = 0;
  int          back2back = 0;
  logic        prev_we  = 1'b0;
  logic [31:0] log_data [0:127];
  logic [31:0] log_addr [0:127];

  instr_stream_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk_i),
    .reset        (reset),
    .instr_i      (instr_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .run_o        (run_o),
    .word_cnt_o   (word_cnt_o),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Mid-cycle monitor: logs writes and run pulses, counts back-to-back writes.
  always @(negedge clk_i) begin
    if (imem_we_o) begin
      if (wr_n < 128) begin
        log_data[wr_n] = imem_wdata_o;
        log_addr[wr_n] = 32'(imem_addr_o);
      end
      wr_n = wr_n + 1;
    end
    if (imem_we_o && prev_we) back2back = back2back + 1;
    prev_we = imem_we_o;
    if (run_o) run_cnt = run_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i);
    instr_i = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_log();
    wr_n    = 0;
    run_cnt = 0;
  endtask

  function automatic logic [7:0] ovf_byte(input int w, input int j);
    return 8'((4 * w + j) & 8'h7F);
  endfunction

  initial begin
    instr_i = 8'h00;
    reset   = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_we",    32'(imem_we_o),    32'd0);
    check_eq("rst_addr",  32'(imem_addr_o),  32'd0);
    check_eq("rst_wdata", imem_wdata_o,      32'd0);
    check_eq("rst_flags", {27'd0, busy_o, done_o, run_o, err_o, 1'b0}, 32'd0);
    check_eq("rst_cnt",   32'(word_cnt_o),   32'd0);
    @(negedge clk_i);
    reset = 1'b0;

    // Basic two-word image.
    clear_log();
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hFE);
    check_eq("t1_busy_on", 32'(busy_o), 32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check_eq("t1_we_early", 32'(imem_we_o), 32'd0);
    send_byte(8'h44);
    check_eq("t1_we_lat",   32'(imem_we_o),   32'd1);
    check_eq("t1_addr0",    32'(imem_addr_o), 32'd0);
    check_eq("t1_data0",    imem_wdata_o,     32'h11223344);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    send_byte(8'hFF);
    check_eq("t1_done",  32'(done_o), 32'd1);
    check_eq("t1_run",   32'(run_o),  32'd1);
    check_eq("t1_busy",  32'(busy_o), 32'd0);
    send_byte(8'h00);
    check_eq("t1_run_1cyc", 32'(run_o), 32'd0);
    check_eq("t1_done_hold", 32'(done_o), 32'd1);
    check_eq("t1_wr_n",  wr_n, 32'd2);
    check_eq("t1_addr1", log_addr[1], 32'd1);
    check_eq("t1_data1", log_data[1], 32'h55667788);
    check_eq("t1_cnt",   32'(word_cnt_o), 32'd2);
    check_eq("t1_err",   32'(err_o), 32'd0);
    check_eq("t1_runs",  run_cnt, 32'd1);

    // Escaped framing bytes as payload; restart from DONE.
    clear_log();
    send_byte(8'hFE);
    check_eq("t2_restart_done", 32'(done_o), 32'd0);
    check_eq("t2_restart_busy", 32'(busy_o), 32'd1);
    send_byte(8'hFD); send_byte(8'hFF);
    send_byte(8'hFD); send_byte(8'hFE);
    send_byte(8'hFD); send_byte(8'hFD);
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h00);
    check_eq("t2_wr_n", wr_n, 32'd1);
    check_eq("t2_addr", log_addr[0], 32'd0);
    check_eq("t2_data", log_data[0], 32'hFFFEFD01);
    check_eq("t2_err",  32'(err_o), 32'd0);
    check_eq("t2_runs", run_cnt, 32'd1);

    // Partial word at end.
    clear_log();
    send_byte(8'hFE); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hFF);
    send_byte(8'h00);
    check_eq("t3_wr_n", wr_n, 32'd0);
    check_eq("t3_err",  32'(err_o), 32'd1);
    check_eq("t3_done", 32'(done_o), 32'd1);
    check_eq("t3_runs", run_cnt, 32'd0);

    // Overflow: start byte in DONE clears error, then 65 words.
    clear_log();
    send_byte(8'hFE);
    check_eq("t4_err_clr",  32'(err_o),  32'd0);
    check_eq("t4_done_clr", 32'(done_o), 32'd0);
    for (int w = 0; w < 65; w++)
      for (int j = 0; j < 4; j++)
        send_byte(ovf_byte(w, j));
    send_byte(8'h00);
    check_eq("t4_err_early", 32'(err_o), 32'd1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);  // one more full word, also dropped
    send_byte(8'hFF);
    send_byte(8'h00);
    check_eq("t4_wr_n",  wr_n, 32'd64);
    check_eq("t4_addr63", log_addr[63], 32'd63);
    check_eq("t4_data63", log_data[63],
             {ovf_byte(63, 0), ovf_byte(63, 1), ovf_byte(63, 2), ovf_byte(63, 3)});
    check_eq("t4_data10", log_data[10],
             {ovf_byte(10, 0), ovf_byte(10, 1), ovf_byte(10, 2), ovf_byte(10, 3)});
    check_eq("t4_cnt",  32'(word_cnt_o), 32'd64);
    check_eq("t4_err",  32'(err_o), 32'd1);
    check_eq("t4_runs", run_cnt, 32'd0);

    // Checksum trailer; without the macro the trailing byte is ignored in DONE.
    clear_log();
    send_byte(8'hFE); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hFF); send_byte(8'h04); send_byte(8'h00);
    check_eq("t5_ok_err",  32'(err_o), 32'd0);
    check_eq("t5_ok_runs", run_cnt, 32'd1);
    check_eq("t5_ok_done", 32'(done_o), 32'd1);
    clear_log();
    send_byte(8'hFE); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'hFF); send_byte(8'h05); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    check_eq("t5_bad_err",  32'(err_o), 32'd1);
    check_eq("t5_bad_runs", run_cnt, 32'd0);
`else
    check_eq("t5_bad_err",  32'(err_o), 32'd0);
    check_eq("t5_bad_runs", run_cnt, 32'd1);
`endif
    check_eq("t5_bad_wr_n", wr_n, 32'd1);

    // Reset mid-image.
    clear_log();
    send_byte(8'hFE);
    for (int k = 0; k < 10; k++) send_byte(8'(8'h20 + k));
    check_eq("t6_cnt_pre",  32'(word_cnt_o), 32'd2);
    check_eq("t6_busy_pre", 32'(busy_o), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_rst_busy",  32'(busy_o), 32'd0);
    check_eq("t6_rst_cnt",   32'(word_cnt_o), 32'd0);
    check_eq("t6_rst_addr",  32'(imem_addr_o), 32'd0);
    check_eq("t6_rst_wdata", imem_wdata_o, 32'd0);
    @(negedge clk_i);
    reset = 1'b0;
    clear_log();
    send_byte(8'hFE); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C); send_byte(8'h0E);
    check_eq("t6_we",   32'(imem_we_o), 32'd1);
    check_eq("t6_addr", 32'(imem_addr_o), 32'd0);
    check_eq("t6_data", imem_wdata_o, 32'h0A0B0C0E);
    check_eq("t6_cnt",  32'(word_cnt_o), 32'd1);

    check_eq("no_back2back", back2back, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/instr_stream_loader.md
# instr_stream_loader

Receive-side boot loader that consumes the byte-per-cycle instruction stream driven into the CPU on `instr_i` and writes it into instruction memory. It sits between the CPU's `instr_i` pin and the instruction-memory write port. Its job:
- frame the stream with start, end and escape bytes;
- pack every four payload bytes into one 32-bit word;
- write words to consecutive addresses;
- signal the core to run once the image is complete.

## Interface
Parameters:
- `ADDR_W`, default 6: instruction-memory word-address width; depth is 2^ADDR_W words.
- `START_BYTE`, default 8'hFE: start-of-image marker.
- `END_BYTE`, default 8'hFF: end-of-image marker.
- `ESC_BYTE`, default 8'hFD: escape; the next byte is always taken as literal payload.

Ports (all outputs registered):
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `instr_i`  in  8: stream byte, sampled on every rising edge (no valid strobe).
- `imem_we_o`  out  1: instruction-memory write enable, one cycle per completed word.
- `imem_addr_o`  out  ADDR_W: word address of the write.
- `imem_wdata_o`  out  32: packed word; the first byte received is placed in [31:24].
- `busy_o`  out  1: high in LOAD, ESC and CKSUM.
- `done_o`  out  1: image complete; level signal, held until the next start byte.
- `run_o`  out  1: single-cycle pulse on entering DONE with `err_o` low.
- `word_cnt_o`  out  ADDR_W+1: number of words written in the current image.
- `err_o`  out  1: sticky error flag; cleared only by a start byte or reset.

## Operation
States: IDLE, LOAD, ESC, CKSUM (macro only), DONE.

IDLE:
- `START_BYTE` → LOAD. On entry clear the byte index, address, `word_cnt_o`, `err_o` and `done_o`.
- Any other byte is ignored.

LOAD:
- `ESC_BYTE` → ESC; the byte itself is discarded.
- `END_BYTE` → CKSUM if `LOADER_CHECKSUM_EN` is defined, otherwise DONE.
- Any other byte, including `START_BYTE`, is payload: shift it into the word buffer and increment the 2-bit byte index.

ESC:
- The sampled byte is payload regardless of value, processed exactly as a LOAD payload byte; then → LOAD.

Word completion (byte index wraps 3→0):
- Assert `imem_we_o` with the current address and buffer contents.
- Increment the address and `word_cnt_o`.

Overflow:
- A completed word when `word_cnt_o` == 2^ADDR_W is not written (`imem_we_o` stays low).
- Set `err_o`; `word_cnt_o` saturates; loading continues until the end byte.

End byte with byte index ≠ 0:
- Discard the partial word and set `err_o`.

DONE:
- `START_BYTE` restarts the load exactly as from IDLE.
- Other bytes are ignored.
- `done_o` stays high; `run_o` is emitted only on the DONE entry cycle.

Reset:
- Reset mid-operation returns to IDLE immediately.
- Words already written remain in memory; the loader performs no erase.

## Timing
- Reset values: every output is 0 (`imem_addr_o` 0, `imem_wdata_o` 0, `word_cnt_o` 0).
- Write latency: if the 4th payload byte is sampled at edge k, `imem_we_o` is high for the cycle after edge k. `imem_addr_o` and `imem_wdata_o` are valid in that same cycle.
- `imem_we_o` is never high on two consecutive cycles; the minimum spacing is 4 cycles, or more with escapes.
- End byte sampled at edge k (no macro): `done_o` rises after edge k and `run_o` is high for that one cycle only. `busy_o` falls at the same edge.
- End byte as the 5th byte after a completed word: the word write at k-1 completes normally; END at k adds no write.
- Start byte sampled at edge k in DONE: `done_o` and `err_o` fall after edge k and `busy_o` rises.

## Configuration
`LOADER_CHECKSUM_EN` defined:
- The LOAD→CKSUM transition is taken on the end byte.
- The byte following END is compared, unescaped, against the running XOR of all payload bytes since START.
- On mismatch, set `err_o`. Either way → DONE one edge later.
- `run_o` is suppressed if `err_o` is set.

Not defined:
- No CKSUM state and no XOR register.
- END goes directly to DONE.

## Test plan
- Zeros, then FE, 11 22 33 44, 55 66 77 88, FF → writes at addr 0 (32'h11223344) and addr 1 (32'h55667788); `word_cnt_o`=2; `done_o`=1; one `run_o` pulse; `err_o`=0.
- FE, FD FF, FD FE, FD FD, 01, FF → a single write of 32'hFFFEFD01 at addr 0, no error.
- FE, AA BB, FF → no write; `err_o`=1; `done_o`=1; no `run_o`.
- 65 words streamed with `ADDR_W`=6 → 64 writes at addresses 0–63, 65th word dropped, `err_o`=1, `word_cnt_o`=64.
- Reset asserted after 2 of 3 words → all outputs 0 immediately, state IDLE; a subsequent FE reload writes from addr 0.
- With `LOADER_CHECKSUM_EN`: FE 01 02 03 04 FF 04 → `err_o`=0 and `run_o` pulse. Same stream with a final 05 → `err_o`=1 and no `run_o`.
